// File: rtl/bmp180_pkg.sv
// Shared definitions for the BMP180 byte collector: frame types, byte counts
// and collector FSM states.
package bmp180_pkg;

  typedef enum logic [1:0] {
    FT_ID  = 2'd0,
    FT_CAL = 2'd1,
    FT_UT  = 2'd2,
    FT_UP  = 2'd3
  } frame_type_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  localparam int         CAL_WORDS = 11;
  localparam logic [4:0] ID_BYTES  = 5'd1;
  localparam logic [4:0] CAL_BYTES = 5'd22;
  localparam logic [4:0] UT_BYTES  = 5'd2;
  localparam logic [4:0] UP_BYTES  = 5'd3;

  function automatic logic [4:0] frame_bytes(input frame_type_t ft);
    logic [4:0] n;
    n = ID_BYTES;
    case (ft)
      FT_ID:  n = ID_BYTES;
      FT_CAL: n = CAL_BYTES;
      FT_UT:  n = UT_BYTES;
      FT_UP:  n = UP_BYTES;
      default: n = ID_BYTES;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/bmp180_cal_regfile.sv
// 11 x 16-bit calibration word store: one write port, one registered read port.
// Out-of-range read addresses return zero.
module bmp180_cal_regfile
  import bmp180_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  i_wr_idx,
  input  logic [15:0] i_wr_data,
  input  logic        i_wr_en,
  input  logic [3:0]  i_rd_addr,
  output logic [15:0] o_rd_data
);

  logic [15:0] r_words [CAL_WORDS];
  logic [15:0] r_rd_data;

  for (genvar gi = 0; gi < CAL_WORDS; gi++) begin : g_word
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_words[gi] <= '0;
      end else if (i_wr_en && (i_wr_idx == 4'(gi))) begin
        r_words[gi] <= i_wr_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data <= '0;
    end else if (int'(i_rd_addr) < CAL_WORDS) begin
      r_rd_data <= r_words[i_rd_addr];
    end else begin
      r_rd_data <= '0;
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/bmp180_data_collector.sv
// Assembles BMP180 I2C byte streams into chip ID, calibration words and raw
// temperature/pressure readings, committing results one frame at a time.
module bmp180_data_collector
  import bmp180_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        received,
  input  logic [7:0]  datareceive,
  input  logic        frameStart,
  input  logic [1:0]  frameType,
  input  logic [1:0]  oss,
  input  logic        errClr,
  input  logic [3:0]  rdAddr,
  output logic [15:0] rdData,
  output logic [7:0]  chipId,
  output logic [15:0] ut,
  output logic [18:0] up,
  output logic        calValid,
  output logic        busy,
  output logic        frameDone,
  output logic        error
);

  state_t      r_state;
  frame_type_t r_type;
  logic [1:0]  r_oss;
  logic [4:0]  r_count;
  logic [23:0] r_shadow;
  logic        r_rcv_prev;
  logic [7:0]  r_chip_id;
  logic [15:0] r_ut;
  logic [18:0] r_up;
  logic        r_cal_valid;
  logic        r_busy;
  logic        r_frame_done;
  logic        r_error;

  logic        w_edge;
  logic        w_full;
  logic        w_take;
  logic        w_err_set;
  logic        w_cal_we;
  logic [3:0]  w_cal_idx;
  logic [15:0] w_cal_data;
  logic [23:0] w_up_shifted;

  assign w_edge       = received & ~r_rcv_prev;
  assign w_full       = (r_count == frame_bytes(r_type));
  assign w_take       = (r_state == ST_COLLECT) && w_edge && !frameStart && !w_full;
  // A byte edge outside COLLECT is a protocol error unless a new frame opens on it.
  assign w_err_set    = w_edge && !frameStart && (r_state != ST_COLLECT);
  assign w_cal_we     = w_take && (r_type == FT_CAL) && r_count[0];
  assign w_cal_idx    = r_count[4:1];
  assign w_cal_data   = {r_shadow[7:0], datareceive};
  assign w_up_shifted = r_shadow >> (4'd8 - {2'b00, r_oss});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_type       <= FT_ID;
      r_oss        <= '0;
      r_count      <= '0;
      r_shadow     <= '0;
      r_rcv_prev   <= 1'b0;
      r_chip_id    <= '0;
      r_ut         <= '0;
      r_up         <= '0;
      r_cal_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_rcv_prev   <= received;
      r_frame_done <= 1'b0;
      r_error      <= w_err_set | (r_error & ~errClr);
      if (frameStart) begin
        r_state  <= ST_COLLECT;
        r_type   <= frame_type_t'(frameType);
        r_oss    <= oss;
        r_count  <= '0;
        r_shadow <= '0;
        r_busy   <= 1'b1;
        if (frame_type_t'(frameType) == FT_CAL) begin
          r_cal_valid <= 1'b0;
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
          end
          ST_COLLECT: begin
            if (w_full) begin
              // Results land on entry to DONE so they are valid alongside frameDone.
              r_state      <= ST_DONE;
              r_busy       <= 1'b0;
              r_frame_done <= 1'b1;
              case (r_type)
                FT_ID:  r_chip_id   <= r_shadow[7:0];
                FT_CAL: r_cal_valid <= 1'b1;
                FT_UT:  r_ut        <= r_shadow[15:0];
                FT_UP:  r_up        <= w_up_shifted[18:0];
                default: begin
                end
              endcase
            end else if (w_take) begin
              r_count  <= r_count + 5'd1;
              r_shadow <= {r_shadow[15:0], datareceive};
            end
          end
          ST_DONE: r_state <= ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  bmp180_cal_regfile u_cal_regfile (
    .clk       (clk),
    .rst       (reset),
    .i_wr_idx  (w_cal_idx),
    .i_wr_data (w_cal_data),
    .i_wr_en   (w_cal_we),
    .i_rd_addr (rdAddr),
    .o_rd_data (rdData)
  );

  assign chipId    = r_chip_id;
  assign ut        = r_ut;
  assign up        = r_up;
  assign calValid  = r_cal_valid;
  assign busy      = r_busy;
  assign frameDone = r_frame_done;
  assign error     = r_error;

endmodule

// File: tb/tb_bmp180_data_collector.sv
// Bench for the BMP180 byte collector: frame-level reference model compared
// every cycle, plus literal checks on the key frames.
module tb_bmp180_data_collector;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        received = 1'b0;
  logic [7:0]  datareceive = 8'h00;
  logic        frameStart = 1'b0;
  logic [1:0]  frameType = 2'd0;
  logic [1:0]  oss = 2'd0;
  logic        errClr = 1'b0;
  logic [3:0]  rdAddr = 4'd0;
  logic [15:0] rdData;
  logic [7:0]  chipId;
  logic [15:0] ut;
  logic [18:0] up;
  logic        calValid;
  logic        busy;
  logic        frameDone;
  logic        error;

  always #5 clk = ~clk;

  bmp180_data_collector dut (
    .clk         (clk),
    .reset       (reset),
    .received    (received),
    .datareceive (datareceive),
    .frameStart  (frameStart),
    .frameType   (frameType),
    .oss         (oss),
    .errClr      (errClr),
    .rdAddr      (rdAddr),
    .rdData      (rdData),
    .chipId      (chipId),
    .ut          (ut),
    .up          (up),
    .calValid    (calValid),
    .busy        (busy),
    .frameDone   (frameDone),
    .error       (error)
  );

  int total = 0;
  int bad = 0;
  int fd_pulses = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  logic [15:0] m_words [11];
  logic [7:0]  m_bytes [$];
  logic [7:0]  m_chip = 8'h00;
  logic [15:0] m_ut = 16'h0000;
  logic [18:0] m_up = 19'h0;
  logic [15:0] m_rd = 16'h0000;
  logic        m_cal_valid = 1'b0;
  logic        m_busy = 1'b0;
  logic        m_fd = 1'b0;
  logic        m_err = 1'b0;
  logic        m_prev = 1'b0;
  logic [1:0]  m_type = 2'd0;
  logic [1:0]  m_oss = 2'd0;

  function automatic int need_of(input logic [1:0] t);
    case (t)
      2'd0: return 1;
      2'd1: return 22;
      2'd2: return 2;
      default: return 3;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 11; i++) m_words[i] = 16'h0000;
  end

  always @(posedge clk or posedge reset) begin
    logic        edge_now;
    logic [23:0] raw;
    int          n;
    if (reset) begin
      for (int i = 0; i < 11; i++) m_words[i] = 16'h0000;
      m_bytes.delete();
      m_chip = 0; m_ut = 0; m_up = 0; m_rd = 0;
      m_cal_valid = 0; m_busy = 0; m_fd = 0; m_err = 0; m_prev = 0;
    end else begin
      edge_now = received && !m_prev;
      m_prev = received;
      m_rd = (rdAddr < 4'd11) ? m_words[rdAddr] : 16'h0000;
      m_err = (edge_now && !frameStart && !m_busy) || (m_err && !errClr);
      m_fd = 1'b0;
      if (frameStart) begin
        m_busy = 1'b1;
        m_type = frameType;
        m_oss = oss;
        m_bytes.delete();
        if (frameType == 2'd1) m_cal_valid = 1'b0;
      end else if (m_busy) begin
        n = m_bytes.size();
        if (n == need_of(m_type)) begin
          m_busy = 1'b0;
          m_fd = 1'b1;
          case (m_type)
            2'd0: m_chip = m_bytes[0];
            2'd1: m_cal_valid = 1'b1;
            2'd2: m_ut = {m_bytes[0], m_bytes[1]};
            default: begin
              raw = {m_bytes[0], m_bytes[1], m_bytes[2]};
              m_up = 19'(raw >> (8 - int'(m_oss)));
            end
          endcase
        end else if (edge_now) begin
          m_bytes.push_back(datareceive);
          n = m_bytes.size();
          if (m_type == 2'd1 && (n % 2) == 0)
            m_words[n / 2 - 1] = {m_bytes[n - 2], m_bytes[n - 1]};
        end
      end
    end
  end

  always @(negedge clk) begin
    cmp("rdData", 32'(rdData), 32'(m_rd));
    cmp("chipId", 32'(chipId), 32'(m_chip));
    cmp("ut", 32'(ut), 32'(m_ut));
    cmp("up", 32'(up), 32'(m_up));
    cmp("calValid", 32'(calValid), 32'(m_cal_valid));
    cmp("busy", 32'(busy), 32'(m_busy));
    cmp("frameDone", 32'(frameDone), 32'(m_fd));
    cmp("error", 32'(error), 32'(m_err));
    if (frameDone === 1'b1) fd_pulses++;
  end

  // ---------------- stimulus (every task starts and ends at a negedge) ----------------
  task automatic start_frame(input logic [1:0] t, input logic [1:0] o);
    $display("frameStart type=%0d oss=%0d at %0t", t, o, $time);
    frameStart = 1'b1; frameType = t; oss = o;
    @(negedge clk);
    frameStart = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    $display("byte %h at %0t", b, $time);
    received = 1'b1; datareceive = b;
    @(negedge clk);
    received = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_errclr();
    $display("errClr at %0t", $time);
    errClr = 1'b1;
    @(negedge clk);
    errClr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int pulses_before;

  initial begin
    @(negedge clk);
    cmp("reset chipId", 32'(chipId), 32'h0);
    cmp("reset busy", 32'(busy), 32'h0);
    cmp("reset error", 32'(error), 32'h0);
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);

    // ID frame
    start_frame(2'd0, 2'd0);
    send_byte(8'h55);
    cmp("id frameDone", 32'(frameDone), 32'h1);
    cmp("id chipId", 32'(chipId), 32'h55);
    cmp("id error", 32'(error), 32'h0);
    @(negedge clk);
    cmp("id frameDone end", 32'(frameDone), 32'h0);

    // UT frame
    start_frame(2'd2, 2'd0);
    send_byte(8'h6C);
    cmp("ut after first byte", 32'(ut), 32'h0);
    cmp("ut busy", 32'(busy), 32'h1);
    send_byte(8'hFA);
    cmp("ut value", 32'(ut), 32'h6CFA);

    // UT frame restarted by a frameStart coinciding with a byte edge
    start_frame(2'd2, 2'd0);
    send_byte(8'h12);
    $display("frameStart with byte 99 at %0t", $time);
    frameStart = 1'b1; frameType = 2'd2; received = 1'b1; datareceive = 8'h99;
    @(negedge clk);
    frameStart = 1'b0; received = 1'b0;
    @(negedge clk);
    send_byte(8'h34);
    send_byte(8'h56);
    cmp("ut restart value", 32'(ut), 32'h3456);
    cmp("ut restart error", 32'(error), 32'h0);

    // UP frames
    start_frame(2'd3, 2'd0);
    send_byte(8'h5D); send_byte(8'h23); send_byte(8'h00);
    cmp("up oss0", 32'(up), 32'h05D23);
    start_frame(2'd3, 2'd3);
    send_byte(8'h5D); send_byte(8'h23); send_byte(8'h00);
    cmp("up oss3", 32'(up), 32'h2E918);

    // CAL frame with a live read of word 1 as it fills
    rdAddr = 4'd1;
    start_frame(2'd1, 2'd0);
    for (int i = 0; i < 22; i++) begin
      send_byte(8'(i));
      if (i == 1) cmp("cal word1 pending", 32'(rdData), 32'h0);
      if (i == 3) cmp("cal word1 live", 32'(rdData), 32'h0203);
    end
    cmp("cal valid", 32'(calValid), 32'h1);
    rdAddr = 4'd0;  @(negedge clk);
    cmp("cal rd0", 32'(rdData), 32'h0001);
    rdAddr = 4'd10; @(negedge clk);
    cmp("cal rd10", 32'(rdData), 32'h1415);
    rdAddr = 4'd12; @(negedge clk);
    cmp("cal rd12", 32'(rdData), 32'h0);
    rdAddr = 4'd0;

    // CAL aborted by restart, then aborted again by an ID frame
    pulses_before = fd_pulses;
    start_frame(2'd1, 2'd0);
    for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i));
    cmp("abort calValid", 32'(calValid), 32'h0);
    start_frame(2'd1, 2'd0);
    for (int i = 0; i < 3; i++) send_byte(8'hB0 + 8'(i));
    cmp("abort no frameDone", 32'(fd_pulses - pulses_before), 32'h0);
    cmp("abort error", 32'(error), 32'h0);
    start_frame(2'd0, 2'd0);
    send_byte(8'h77);
    cmp("abort id chipId", 32'(chipId), 32'h77);
    cmp("abort calValid stays", 32'(calValid), 32'h0);

    // Byte in IDLE -> sticky error
    @(negedge clk);
    send_byte(8'h01);
    cmp("idle byte error", 32'(error), 32'h1);
    repeat (3) @(negedge clk);
    cmp("error sticky", 32'(error), 32'h1);
    pulse_errclr();
    cmp("error cleared", 32'(error), 32'h0);
    send_byte(8'h02);
    $display("errClr with byte 03 at %0t", $time);
    errClr = 1'b1; received = 1'b1; datareceive = 8'h03;
    @(negedge clk);
    errClr = 1'b0; received = 1'b0;
    cmp("errclr vs new error", 32'(error), 32'h1);
    @(negedge clk);
    pulse_errclr();
    cmp("error cleared again", 32'(error), 32'h0);

    // Reset mid-UP frame
    start_frame(2'd3, 2'd1);
    send_byte(8'h11);
    $display("reset asserted at %0t", $time);
    #2 reset = 1'b1;
    @(negedge clk);
    cmp("rst up", 32'(up), 32'h0);
    cmp("rst ut", 32'(ut), 32'h0);
    cmp("rst chipId", 32'(chipId), 32'h0);
    cmp("rst busy", 32'(busy), 32'h0);
    #2 reset = 1'b0;
    @(negedge clk);
    send_byte(8'hAA);
    cmp("post-reset byte error", 32'(error), 32'h1);
    cmp("post-reset up", 32'(up), 32'h0);
    cmp("post-reset busy", 32'(busy), 32'h0);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bmp180_data_collector.md
BMP180_DATA_COLLECTOR -- requirements
Module: bmp180_data_collector

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port received  input  1  byte-valid level from I2C master; a new byte is its rising edge.
REQ-004 SHALL have port datareceive  input  8  byte from I2C master, stable while received is high.
REQ-005 SHALL have port frameStart  input  1  one-cycle pulse opening a new frame.
REQ-006 SHALL have port frameType  input  2  sampled with frameStart: 0=ID (1 byte), 1=CAL (22), 2=UT (2), 3=UP (3).
REQ-007 SHALL have port oss  input  2  oversampling setting, sampled with frameStart.
REQ-008 SHALL have port errClr  input  1  one-cycle pulse clearing error.
REQ-009 SHALL have port rdAddr  input  4  calibration word index.
REQ-010 SHALL have port rdData  output  16  calibration word, registered.
REQ-011 SHALL have port chipId  output  8  last committed ID byte.
REQ-012 SHALL have port ut  output  16  last committed uncompensated temperature.
REQ-013 SHALL have port up  output  19  last committed uncompensated pressure.
REQ-014 SHALL have port calValid  output  1  all 11 calibration words captured.
REQ-015 SHALL have port busy  output  1  high in COLLECT.
REQ-016 SHALL have port frameDone  output  1  one-cycle pulse on frame commit.
REQ-017 SHALL have port error  output  1  sticky protocol error.

Function
REQ-018 SHALL detect byte arrival as received high while previous-cycle received low (registered edge detector).
REQ-019 SHALL implement FSM IDLE -> COLLECT on frameStart; COLLECT -> DONE when the byte counter reaches the frameType count; DONE -> IDLE after exactly one cycle.
REQ-020 SHALL hold a 5-bit byte counter, cleared on frameStart and incremented per detected byte in COLLECT.
REQ-021 SHALL, for CAL, latch even-index bytes as MSB and on odd-index bytes write {MSB, byte} to word index>>1 of an 11x16 register file.
REQ-022 SHALL, for UT/UP, shift bytes MSB-first into a 24-bit shadow register; outputs SHALL NOT change before commit.
REQ-023 SHALL on commit (DONE cycle) update: ID -> chipId; UT -> ut = shadow[15:0]; UP -> up = shadow[23:0] >> (8-oss), zero-extended to 19 bits; CAL -> calValid=1.
REQ-024 SHALL assert frameDone only in the DONE cycle; latency from the final byte edge to frameDone is 2 cycles.
REQ-025 SHALL clear calValid on frameStart with frameType=CAL; calValid stays 0 if that frame aborts.
REQ-026 SHALL on frameStart during COLLECT abort the current frame without commit or error and start the new one.
REQ-027 SHALL, on frameStart coinciding with a byte edge, honour frameStart and drop the byte.
REQ-028 SHALL set error on a byte edge in IDLE or DONE; the byte is ignored.
REQ-029 SHALL clear error on errClr; if errClr coincides with a new error condition, error SHALL remain set.
REQ-030 SHALL register rdData = word[rdAddr] one cycle after rdAddr; rdAddr 11..15 return 16'h0000.
REQ-031 SHALL keep rdData reads independent of an ongoing CAL frame (words already written are visible).

Reset
REQ-032 SHALL on reset asynchronously force FSM=IDLE, counter=0, shadow=0, all 11 words=0, chipId=0, ut=0, up=0, rdData=0, calValid=0, busy=0, frameDone=0, error=0, edge-detector history=0.
REQ-033 SHALL on reset mid-frame discard partial data; no commit after reset release.

Structure
REQ-034 SHALL take from shared package bmp180_pkg: frame-type encoding, byte counts (1, 22, 2, 3), CAL_WORDS=11, FSM state encoding.
REQ-035 SHALL place the calibration storage in one sub-module bmp180_cal_regfile (write port: index/data/enable; registered read port).

Verification
REQ-036 SHALL test ID: frameStart type 0, byte 8'h55 -> chipId=8'h55, frameDone pulse 2 cycles after the edge, error=0.
REQ-037 SHALL test UT: bytes 8'h6C, 8'hFA -> ut=16'h6CFA; ut unchanged after the first byte.
REQ-038 SHALL test UP: oss=0, bytes 8'h5D, 8'h23, 8'h00 -> up=19'h05D23; with oss=3 and the same bytes -> up=24'h5D2300>>5=19'h2E918.
REQ-039 SHALL test CAL: 22 bytes 8'h00..8'h15 -> rdAddr=0 gives 16'h0001, rdAddr=10 gives 16'h1415, rdAddr=12 gives 0, calValid=1.
REQ-040 SHALL test abort/error: CAL frame restarted after 5 bytes -> calValid=0, no frameDone; byte edge in IDLE -> error=1 until errClr.
REQ-041 SHALL test reset: reset asserted mid-UP frame -> all outputs 0; a later byte edge without frameStart -> error=1.
